// File: rtl/ppu_reg_port_pkg.sv
// ppu_pkg: register indices, loopy field slices and the VRAM port state
// encoding shared by the PPU register port files.
package ppu_pkg;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_MASK    = 3'd1,
    REG_STATUS  = 3'd2,
    REG_OAMADDR = 3'd3,
    REG_OAMDATA = 3'd4,
    REG_SCROLL  = 3'd5,
    REG_ADDR    = 3'd6,
    REG_DATA    = 3'd7
  } ppu_reg_e;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_REQ  = 1'b1
  } vram_st_e;

  // loopy v/t layout: yyy NN YYYYY XXXXX
  localparam int CX_LSB = 0;
  localparam int CX_W   = 5;
  localparam int CY_LSB = 5;
  localparam int CY_W   = 5;
  localparam int NT_LSB = 10;
  localparam int NT_W   = 2;
  localparam int FY_LSB = 12;
  localparam int FY_W   = 3;

  // $2007 auto-increment: across (1) or down (32), wrapping in 15 bits
  function automatic logic [14:0] v_step(input logic [14:0] v, input logic inc32);
    return v + (inc32 ? 15'd32 : 15'd1);
  endfunction

endpackage

// File: rtl/ppu_reg_port_if.sv
// CPU bus window and VRAM request/ack port of the PPU register block.
// slave = the register port, master = CPU/VRAM side driving it.
interface ppu_reg_port_if #(
  parameter int ADDR_W  = 16,
  parameter int VRAM_AW = 14
);
  logic               cpu_en;
  logic [ADDR_W-1:0]  bus_addr;
  logic               bus_rw_n;
  logic [7:0]         bus_din;
  logic [7:0]         bus_out;

  logic               vram_req;
  logic               vram_we;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_wdata;
  logic [7:0]         vram_rdata;
  logic               vram_ack;

  modport slave (
    input  cpu_en, bus_addr, bus_rw_n, bus_din,
    output bus_out,
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_rdata, vram_ack
  );

  modport master (
    output cpu_en, bus_addr, bus_rw_n, bus_din,
    input  bus_out,
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_rdata, vram_ack
  );
endinterface

// File: rtl/ppu_loopy_regs.sv
// Loopy scroll registers: t, v, fine_x and the shared write toggle w.
// The CPU paths ($2000/$2002/$2005/$2006/$2007 increment) take priority
// over the renderer's v overwrite.
module ppu_loopy_regs
  import ppu_pkg::*;
(
  input  logic        Clk,
  input  logic        Res_n,
  input  logic        wr_ctrl,
  input  logic        rd_status,
  input  logic        wr_scroll,
  input  logic        wr_addr,
  input  logic        v_inc,
  input  logic        inc32,
  input  logic [7:0]  din,
  input  logic        rend_v_we,
  input  logic [14:0] rend_v,
  output logic [14:0] t,
  output logic [14:0] v,
  output logic [2:0]  fine_x
);

  logic        w;
  logic [14:0] t_d;

  // next t from whichever CPU write hits this cycle
  always_comb begin
    t_d = t;
    if (wr_ctrl) begin
      t_d[NT_LSB +: NT_W] = din[1:0];
    end else if (wr_scroll) begin
      if (!w) begin
        t_d[CX_LSB +: CX_W] = din[7:3];
      end else begin
        t_d[FY_LSB +: FY_W] = din[2:0];
        t_d[CY_LSB +: CY_W] = din[7:3];
      end
    end else if (wr_addr) begin
      if (!w) begin
        t_d[13:8] = din[5:0];
        t_d[14]   = 1'b0;
      end else begin
        t_d[7:0]  = din;
      end
    end
  end

  // t / fine_x / w state
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      t      <= '0;
      fine_x <= '0;
      w      <= 1'b0;
    end else begin
      t <= t_d;
      if (wr_scroll && !w) fine_x <= din[2:0];
      if (rd_status)                w <= 1'b0;
      else if (wr_scroll || wr_addr) w <= ~w;
    end
  end

  // v: second $2006 write copies t, then $2007 step, then renderer
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n)            v <= '0;
    else if (wr_addr && w) v <= t_d;
    else if (v_inc)        v <= v_step(v, inc32);
    else if (rend_v_we)    v <= rend_v;
  end

endmodule

// File: rtl/ppu_reg_port.sv
// PPU register window $2000-$3FFF (8-byte mirror): PPUCTRL/MASK/STATUS,
// PPUDATA read buffer, NMI generation and a single-outstanding VRAM port.
// Optional OAM port ($2003/$2004) enabled by defining PPU_OAM_PORT_EN.
module ppu_reg_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int VRAM_AW = 14
)(
  input  logic        Clk,
  input  logic        Res_n,
  ppu_reg_port_if.slave bus,
  output logic        nmi_n,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [14:0] t_addr,
  output logic [14:0] v_addr,
  output logic [2:0]  fine_x,
  input  logic        rend_v_we,
  input  logic [14:0] rend_v,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_set,
  input  logic        ovf_set,
  output logic        err_ovr
`ifdef PPU_OAM_PORT_EN
  ,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata
`endif
);

  logic [ADDR_W-1:0] addr;
  logic              unused_addr;
  logic              cs, cs_wr, cs_rd;
  ppu_reg_e          reg_idx;

  assign addr        = bus.bus_addr;
  assign unused_addr = ^addr;
  assign cs          = bus.cpu_en & (addr[15:13] == 3'b001);
  assign cs_wr       = cs & ~bus.bus_rw_n;
  assign cs_rd       = cs &  bus.bus_rw_n;
  assign reg_idx     = ppu_reg_e'(addr[2:0]);

  logic [7:0] io_latch, rd_buf, rd_val;
  logic       vbl, spr0, ovf;
  logic       rd_status;

  assign rd_status = cs_rd & (reg_idx == REG_STATUS);

  // open-bus latch and write-only registers
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      io_latch <= '0;
      ctrl     <= '0;
      mask     <= '0;
    end else if (cs_wr) begin
      io_latch <= bus.bus_din;
      if (reg_idx == REG_CTRL) ctrl <= bus.bus_din;
      if (reg_idx == REG_MASK) mask <= bus.bus_din;
    end
  end

  // status flags; a $2002 read racing vblank_set suppresses vbl for the frame
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      vbl  <= 1'b0;
      spr0 <= 1'b0;
      ovf  <= 1'b0;
    end else if (vblank_clr) begin
      vbl  <= 1'b0;
      spr0 <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (rd_status)       vbl <= 1'b0;
      else if (vblank_set) vbl <= 1'b1;
      if (spr0_set) spr0 <= 1'b1;
      if (ovf_set)  ovf  <= 1'b1;
    end
  end

  // NMI is a registered copy of vbl & enable
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) nmi_n <= 1'b1;
    else        nmi_n <= ~(vbl & ctrl[7]);
  end

  // VRAM port FSM
  vram_st_e st_q, st_d;
  logic     data_acc, data_go, data_drop;

  assign data_acc = cs & (reg_idx == REG_DATA);

  // state register
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) st_q <= VS_IDLE;
    else        st_q <= st_d;
  end

  // next state; a $2007 access during REQ is dropped
  always_comb begin
    st_d         = st_q;
    bus.vram_req = 1'b0;
    data_go      = 1'b0;
    data_drop    = 1'b0;
    case (st_q)
      VS_IDLE: begin
        if (data_acc) begin
          data_go = 1'b1;
          st_d    = VS_REQ;
        end
      end
      VS_REQ: begin
        bus.vram_req = 1'b1;
        data_drop    = data_acc;
        if (bus.vram_ack) st_d = VS_IDLE;
      end
      default: st_d = VS_IDLE;
    endcase
  end

  // request fields captured at issue so they hold through REQ
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      bus.vram_we    <= 1'b0;
      bus.vram_addr  <= '0;
      bus.vram_wdata <= '0;
    end else if (data_go) begin
      bus.vram_we   <= ~bus.bus_rw_n;
      bus.vram_addr <= VRAM_AW'(v_addr[13:0]);
      if (!bus.bus_rw_n) bus.vram_wdata <= bus.bus_din;
    end
  end

  // PPUDATA read buffer and sticky overrun flag
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      rd_buf  <= '0;
      err_ovr <= 1'b0;
    end else begin
      if (st_q == VS_REQ && bus.vram_ack && !bus.vram_we) rd_buf <= bus.vram_rdata;
      if (data_drop) err_ovr <= 1'b1;
    end
  end

  // read data mux
  always_comb begin
    rd_val = io_latch;
    case (reg_idx)
      REG_STATUS:  rd_val = {vbl & ~vblank_set, spr0, ovf, io_latch[4:0]};
      REG_DATA:    rd_val = rd_buf;
`ifdef PPU_OAM_PORT_EN
      REG_OAMDATA: rd_val = oam_rdata;
`endif
      default:     rd_val = io_latch;
    endcase
  end

  // registered read data, held until the next cs read
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n)     bus.bus_out <= '0;
    else if (cs_rd) bus.bus_out <= rd_val;
  end

`ifdef PPU_OAM_PORT_EN
  // OAM write pulse; the address steps the cycle after the pulse so the
  // write lands at the pre-increment address
  always_ff @(posedge Clk or negedge Res_n) begin
    if (!Res_n) begin
      oam_addr  <= '0;
      oam_we    <= 1'b0;
      oam_wdata <= '0;
    end else begin
      oam_we <= cs_wr & (reg_idx == REG_OAMDATA);
      if (cs_wr && reg_idx == REG_OAMDATA) oam_wdata <= bus.bus_din;
      if (cs_wr && reg_idx == REG_OAMADDR) oam_addr <= bus.bus_din;
      else if (oam_we)                     oam_addr <= oam_addr + 8'd1;
    end
  end
`endif

  ppu_loopy_regs u_loopy (
    .Clk       (Clk),
    .Res_n     (Res_n),
    .wr_ctrl   (cs_wr & (reg_idx == REG_CTRL)),
    .rd_status (rd_status),
    .wr_scroll (cs_wr & (reg_idx == REG_SCROLL)),
    .wr_addr   (cs_wr & (reg_idx == REG_ADDR)),
    .v_inc     (data_go),
    .inc32     (ctrl[2]),
    .din       (bus.bus_din),
    .rend_v_we (rend_v_we),
    .rend_v    (rend_v),
    .t         (t_addr),
    .v         (v_addr),
    .fine_x    (fine_x)
  );

endmodule

// File: tb/tb_ppu_reg_port.sv
// Self-checking bench for ppu_reg_port: randomized register traffic
// against a behavioural model of the register window.
module tb_ppu_reg_port;
  import ppu_pkg::*;

  logic Clk = 1'b0;
  logic Res_n = 1'b0;
  always #5 Clk = ~Clk;

  ppu_reg_port_if #(.ADDR_W(16), .VRAM_AW(14)) bus ();

  logic        nmi_n, err_ovr;
  logic [7:0]  ctrl, mask;
  logic [14:0] t_addr, v_addr;
  logic [2:0]  fine_x;
  logic        rend_v_we = 1'b0;
  logic [14:0] rend_v = '0;
  logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_set = 1'b0, ovf_set = 1'b0;
`ifdef PPU_OAM_PORT_EN
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata = '0;
`endif

  ppu_reg_port dut (
    .Clk(Clk), .Res_n(Res_n), .bus(bus),
    .nmi_n(nmi_n), .ctrl(ctrl), .mask(mask), .t_addr(t_addr), .v_addr(v_addr),
    .fine_x(fine_x), .rend_v_we(rend_v_we), .rend_v(rend_v),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_set(spr0_set),
    .ovf_set(ovf_set), .err_ovr(err_ovr)
`ifdef PPU_OAM_PORT_EN
    , .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [14:0] m_t, m_v;
  logic        m_w, m_vbl, m_spr0, m_ovf, m_pend, m_req_we, m_err;
  logic [2:0]  m_fx;
  logic [7:0]  m_ctrl, m_mask, m_io, m_rdbuf, m_req_wd, m_bus;
  logic [13:0] m_req_addr;

  task automatic model_reset();
    m_t = '0; m_v = '0; m_w = 0; m_vbl = 0; m_spr0 = 0; m_ovf = 0; m_pend = 0;
    m_req_we = 0; m_err = 0; m_fx = '0; m_ctrl = '0; m_mask = '0; m_io = '0;
    m_rdbuf = '0; m_req_wd = '0; m_bus = '0; m_req_addr = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] ra(input logic [2:0] r);
    logic [9:0] mid;
    mid = 10'($urandom);
    return {3'b001, mid, r};
  endfunction

  // one CPU bus cycle; model updated from the register rules
  task automatic acc(input logic [15:0] a, input logic en, input logic rw,
                     input logic [7:0] d, input logic vset, output logic [7:0] exp_rd);
    logic sel, v_upd, rwe;
    logic [2:0] r;
    logic [14:0] rv;
    int inc;
    rwe = rend_v_we; rv = rend_v;
    bus.cpu_en = en; bus.bus_addr = a; bus.bus_rw_n = rw; bus.bus_din = d; vblank_set = vset;
    @(posedge Clk); #1;
    bus.cpu_en = 0; vblank_set = 0;
    sel = en && (a[15:13] == 3'b001); r = a[2:0]; v_upd = 0;
    inc = m_ctrl[2] ? 32 : 1;
    if (sel && r == 3'd7) begin
      if (m_pend) m_err = 1;
      else begin
        m_pend = 1; m_req_we = !rw; m_req_addr = m_v[13:0];
        if (!rw) m_req_wd = d;
        m_v = 15'((int'(m_v) + inc) % 32768); v_upd = 1;
      end
    end
    if (sel && rw) begin
      if (r == 3'd2) begin
        m_bus = {m_vbl & ~vset, m_spr0, m_ovf, m_io[4:0]};
        m_vbl = 0; m_w = 0;
      end else if (r == 3'd7) m_bus = m_rdbuf;
      else m_bus = m_io;
    end
    if (sel && !rw) begin
      m_io = d;
      case (r)
        3'd0: begin m_ctrl = d; m_t = 15'((int'(m_t) & ~(3 << 10)) | ((int'(d) & 3) << 10)); end
        3'd1: m_mask = d;
        3'd5: begin
          if (!m_w) begin m_t = 15'((int'(m_t) & ~31) | (int'(d) >> 3)); m_fx = d[2:0]; end
          else m_t = 15'((int'(m_t) & ~(7 << 12) & ~(31 << 5)) | ((int'(d) & 7) << 12) | ((int'(d) >> 3) << 5));
          m_w = !m_w;
        end
        3'd6: begin
          if (!m_w) m_t = 15'((int'(m_t) & 255) | ((int'(d) & 63) << 8));
          else begin m_t = 15'((int'(m_t) & 16'h7F00) | int'(d)); m_v = m_t; v_upd = 1; end
          m_w = !m_w;
        end
        default: ;
      endcase
    end
    if (vset && !(sel && rw && r == 3'd2)) m_vbl = 1;
    if (rwe && !v_upd) m_v = rv;
    exp_rd = m_bus;
  endtask

  task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
    vblank_set = vs; vblank_clr = vc; spr0_set = s0; ovf_set = ov;
    @(posedge Clk); #1;
    vblank_set = 0; vblank_clr = 0; spr0_set = 0; ovf_set = 0;
    if (vc) begin m_vbl = 0; m_spr0 = 0; m_ovf = 0; end
    else begin if (vs) m_vbl = 1; if (s0) m_spr0 = 1; if (ov) m_ovf = 1; end
  endtask

  task automatic ack(input logic [7:0] rd);
    bus.vram_ack = 1; bus.vram_rdata = rd;
    @(posedge Clk); #1;
    bus.vram_ack = 0;
    if (m_pend) begin if (!m_req_we) m_rdbuf = rd; m_pend = 0; end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    Res_n = 0; model_reset();
    #12;
    vectors++; if ({bus.bus_out, nmi_n, bus.vram_req, err_ovr} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin miscompares++; $display("FAIL rst_outs got=%h", {bus.bus_out, nmi_n, bus.vram_req, err_ovr}); end
    vectors++; if ({ctrl, mask, t_addr, v_addr, fine_x} !== '0) begin miscompares++; $display("FAIL rst_regs got=%h exp=0", {ctrl, mask, t_addr, v_addr, fine_x}); end
    Res_n = 1;
    tick(1);
    acc(16'h2000, 1, 1, 8'h00, 0, e);
    vectors++; if (bus.bus_out !== 8'h00) begin miscompares++; $display("FAIL rst_rd2000 got=%h exp=00", bus.bus_out); end
    acc(16'h2002, 1, 1, 8'h00, 0, e);
    vectors++; if (bus.bus_out !== e || nmi_n !== 1'b1) begin miscompares++; $display("FAIL rst_rd2002 got=%h/%b exp=%h/1", bus.bus_out, nmi_n, e); end
  endtask

  task automatic test_addr();
    logic [7:0] e;
    acc(ra(6), 1, 0, 8'h21, 0, e);
    acc(ra(6), 1, 0, 8'h08, 0, e);
    vectors++; if (t_addr !== 15'h2108 || v_addr !== 15'h2108 || t_addr !== m_t) begin miscompares++; $display("FAIL addr_pair t=%h v=%h exp=2108", t_addr, v_addr); end
    acc(ra(6), 1, 0, 8'h3F, 0, e);
    vectors++; if (t_addr !== 15'h3F08 || v_addr !== 15'h2108) begin miscompares++; $display("FAIL addr_third t=%h v=%h exp=3f08/2108", t_addr, v_addr); end
  endtask

  task automatic test_regs_random();
    logic [7:0] e, d;
    logic [2:0] r;
    logic rw;
    for (int i = 0; i < 40; i++) begin
      r = 3'($urandom_range(0, 6)); rw = 1'($urandom); d = 8'($urandom);
`ifdef PPU_OAM_PORT_EN
      if (r == 3'd4 && rw) r = 3'd3;
`endif
      acc(ra(r), 1, rw, d, 0, e);
      if (rw) begin
        vectors++; if (bus.bus_out !== e) begin miscompares++; $display("FAIL rnd_rd%0d got=%h exp=%h", r, bus.bus_out, e); end
      end
      vectors++; if ({ctrl, mask, t_addr, v_addr, fine_x} !== {m_ctrl, m_mask, m_t, m_v, m_fx}) begin miscompares++; $display("FAIL rnd_regs it=%0d got=%h exp=%h", i, {ctrl, mask, t_addr, v_addr, fine_x}, {m_ctrl, m_mask, m_t, m_v, m_fx}); end
    end
  endtask

  task automatic test_data_write();
    logic [7:0] e;
    acc(ra(2), 1, 1, 0, 0, e);
    acc(ra(6), 1, 0, 8'h21, 0, e);
    acc(ra(6), 1, 0, 8'h08, 0, e);
    acc(ra(0), 1, 0, 8'h04, 0, e);
    for (int k = 0; k < 2; k++) begin
      acc(ra(7), 1, 0, 8'hAA, 0, e);
      tick(1);
      vectors++; if ({bus.vram_req, bus.vram_we, bus.vram_addr, bus.vram_wdata} !== {1'b1, 1'b1, m_req_addr, 8'hAA}) begin miscompares++; $display("FAIL dwr_req%0d got=%h exp=%h", k, {bus.vram_req, bus.vram_we, bus.vram_addr, bus.vram_wdata}, {1'b1, 1'b1, m_req_addr, 8'hAA}); end
      ack(8'h00);
      vectors++; if (bus.vram_req !== 1'b0) begin miscompares++; $display("FAIL dwr_done%0d req=%b exp=0", k, bus.vram_req); end
    end
    vectors++; if (m_req_addr !== 14'h2128 || v_addr !== 15'h2148) begin miscompares++; $display("FAIL dwr_v v=%h last=%h exp=2148/2128", v_addr, m_req_addr); end
  endtask

  task automatic test_data_read();
    logic [7:0] e, d;
    logic rw;
    int dl;
    acc(ra(0), 1, 0, 8'h00, 0, e);
    acc(ra(6), 1, 0, 8'h20, 0, e);
    acc(ra(6), 1, 0, 8'h00, 0, e);
    acc(ra(7), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== 8'h00 || bus.vram_addr !== 14'h2000 || bus.vram_we !== 1'b0) begin miscompares++; $display("FAIL drd_1 got=%h/%h exp=00/2000", bus.bus_out, bus.vram_addr); end
    ack(8'h11);
    acc(ra(7), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== 8'h11 || bus.vram_addr !== 14'h2001) begin miscompares++; $display("FAIL drd_2 got=%h/%h exp=11/2001", bus.bus_out, bus.vram_addr); end
    ack(8'h22);
    acc(ra(7), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== 8'h22) begin miscompares++; $display("FAIL drd_buf got=%h exp=22", bus.bus_out); end
    ack(8'h5C);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) acc(ra(0), 1, 0, 8'($urandom), 0, e);
      rw = 1'($urandom); d = 8'($urandom);
      acc(ra(7), 1, rw, d, 0, e);
      if (rw) begin
        vectors++; if (bus.bus_out !== e) begin miscompares++; $display("FAIL drnd_rd it=%0d got=%h exp=%h", i, bus.bus_out, e); end
      end
      dl = $urandom_range(0, 3);
      if (dl != 0) tick(dl);
      vectors++; if ({bus.vram_req, bus.vram_we, bus.vram_addr} !== {1'b1, m_req_we, m_req_addr} || (m_req_we && bus.vram_wdata !== m_req_wd) || v_addr !== m_v) begin miscompares++; $display("FAIL drnd_req it=%0d got=%h/%h v=%h exp=%h/%h v=%h", i, {bus.vram_req, bus.vram_we, bus.vram_addr}, bus.vram_wdata, v_addr, {1'b1, m_req_we, m_req_addr}, m_req_wd, m_v); end
      ack(8'($urandom));
    end
  endtask

  task automatic test_vblank();
    logic [7:0] e;
    acc(ra(0), 1, 0, 8'h80, 0, e);
    pulse(1, 0, 0, 0);
    tick(1);
    vectors++; if (nmi_n !== 1'b0) begin miscompares++; $display("FAIL vbl_nmi_lo got=%b exp=0", nmi_n); end
    acc(ra(2), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e || bus.bus_out !== (8'h80 | (m_io & 8'h1F))) begin miscompares++; $display("FAIL vbl_rd1 got=%h exp=%h", bus.bus_out, e); end
    tick(1);
    vectors++; if (nmi_n !== 1'b1) begin miscompares++; $display("FAIL vbl_nmi_hi got=%b exp=1", nmi_n); end
    acc(ra(2), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e || bus.bus_out[7] !== 1'b0) begin miscompares++; $display("FAIL vbl_rd2 got=%h exp=%h", bus.bus_out, e); end
    acc(ra(2), 1, 1, 0, 1, e);
    vectors++; if (bus.bus_out !== e || bus.bus_out[7] !== 1'b0) begin miscompares++; $display("FAIL vbl_race got=%h exp=%h", bus.bus_out, e); end
    tick(2);
    acc(ra(2), 1, 1, 0, 0, e);
    vectors++; if (nmi_n !== 1'b1 || bus.bus_out !== e) begin miscompares++; $display("FAIL vbl_race_after nmi=%b rd=%h exp=1/%h", nmi_n, bus.bus_out, e); end
    pulse(0, 0, 1, 1);
    acc(ra(2), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e || bus.bus_out[6:5] !== 2'b11) begin miscompares++; $display("FAIL flags_set got=%h exp=%h", bus.bus_out, e); end
    pulse(1, 1, 1, 0);
    acc(ra(2), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e || bus.bus_out[7:5] !== 3'b000) begin miscompares++; $display("FAIL flags_clr got=%h exp=%h", bus.bus_out, e); end
    acc(ra(0), 1, 0, 8'h00, 0, e);
    pulse(1, 0, 0, 0);
    tick(1);
    vectors++; if (nmi_n !== 1'b1) begin miscompares++; $display("FAIL nmi_masked got=%b exp=1", nmi_n); end
    acc(ra(0), 1, 0, 8'h80, 0, e);
    tick(1);
    vectors++; if (nmi_n !== 1'b0) begin miscompares++; $display("FAIL nmi_late_en got=%b exp=0", nmi_n); end
    pulse(0, 1, 0, 0);
    tick(1);
    vectors++; if (nmi_n !== 1'b1) begin miscompares++; $display("FAIL nmi_clr got=%b exp=1", nmi_n); end
  endtask

  task automatic test_rend_v();
    logic [7:0] e;
    acc(ra(2), 1, 1, 0, 0, e);
    rend_v_we = 1; rend_v = 15'($urandom);
    acc(16'h0000, 0, 1, 0, 0, e);
    vectors++; if (v_addr !== m_v || v_addr !== rend_v) begin miscompares++; $display("FAIL rend_only got=%h exp=%h", v_addr, m_v); end
    rend_v = 15'($urandom);
    acc(ra(6), 1, 0, 8'($urandom), 0, e);
    vectors++; if (v_addr !== m_v) begin miscompares++; $display("FAIL rend_first got=%h exp=%h", v_addr, m_v); end
    rend_v = 15'($urandom);
    acc(ra(6), 1, 0, 8'($urandom), 0, e);
    rend_v_we = 0;
    vectors++; if (v_addr !== m_v || v_addr !== m_t) begin miscompares++; $display("FAIL rend_cpu_wins got=%h exp=%h", v_addr, m_v); end
  endtask

  task automatic test_decode();
    logic [7:0] e;
    acc(ra(0), 1, 0, 8'h5A, 0, e);
    acc(16'h0006, 1, 0, 8'hC3, 0, e);
    acc(16'h4006, 1, 0, 8'h3C, 0, e);
    acc(ra(6), 0, 0, 8'h99, 0, e);
    acc(ra(1), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e || e !== m_io) begin miscompares++; $display("FAIL dec_latch got=%h exp=%h", bus.bus_out, e); end
    vectors++; if ({t_addr, v_addr} !== {m_t, m_v}) begin miscompares++; $display("FAIL dec_tv got=%h exp=%h", {t_addr, v_addr}, {m_t, m_v}); end
    acc(16'h6002, 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e) begin miscompares++; $display("FAIL dec_hold got=%h exp=%h", bus.bus_out, e); end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    logic [13:0] first;
    acc(ra(2), 1, 1, 0, 0, e);
    acc(ra(0), 1, 0, 8'h00, 0, e);
    acc(ra(6), 1, 0, 8'($urandom), 0, e);
    acc(ra(6), 1, 0, 8'($urandom), 0, e);
    acc(ra(7), 1, 0, 8'h12, 0, e);
    first = m_req_addr;
    acc(ra(7), 1, 0, 8'h34, 0, e);
    vectors++; if (v_addr !== m_v || err_ovr !== 1'b1 || m_err !== 1'b1) begin miscompares++; $display("FAIL ovr_drop v=%h err=%b exp=%h/1", v_addr, err_ovr, m_v); end
    vectors++; if ({bus.vram_addr, bus.vram_wdata} !== {first, 8'h12}) begin miscompares++; $display("FAIL ovr_hold got=%h exp=%h", {bus.vram_addr, bus.vram_wdata}, {first, 8'h12}); end
    #2 Res_n = 0;
    #1;
    vectors++; if (bus.vram_req !== 1'b0) begin miscompares++; $display("FAIL rst_midreq req=%b exp=0", bus.vram_req); end
    model_reset();
    vectors++; if ({err_ovr, nmi_n, v_addr} !== {m_err, 1'b1, m_v}) begin miscompares++; $display("FAIL rst_mid_state got=%h exp=%h", {err_ovr, nmi_n, v_addr}, {m_err, 1'b1, m_v}); end
    @(posedge Clk); #2 Res_n = 1;
    ack(8'h5A);
    vectors++; if (bus.vram_req !== 1'b0) begin miscompares++; $display("FAIL late_ack req=%b exp=0", bus.vram_req); end
    acc(ra(7), 1, 1, 0, 0, e);
    vectors++; if (bus.bus_out !== e) begin miscompares++; $display("FAIL late_ack_buf got=%h exp=%h", bus.bus_out, e); end
    ack(8'h00);
  endtask

  initial begin
    bus.cpu_en = 0; bus.bus_addr = '0; bus.bus_rw_n = 1; bus.bus_din = '0;
    bus.vram_ack = 0; bus.vram_rdata = '0;
    test_reset();
    test_addr();
    test_regs_random();
    test_data_write();
    test_data_read();
    test_vblank();
    test_rend_v();
    test_decode();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/ppu_reg_port.md
Name: ppu_reg_port

Overview:
- CPU-side responder for the PPU register window $2000-$3FFF (mirrored every 8 bytes). It decodes CPU bus cycles and holds PPUCTRL, PPUMASK, PPUSTATUS, the loopy t/v/w/fine_x registers and the PPUDATA read buffer.
- Exports control state to the renderer and runs a one-outstanding request/ack port to VRAM.
- Sits between the databus (supplying bus_out as VIDEO_BUS) and the PPU renderer.

Parameters:
- ADDR_W, 16, CPU address width seen at the port (upper bits beyond 15 ignored)
- VRAM_AW, 14, VRAM address width driven on vram_addr

Ports:
- Clk  in  1  PPU/CPU shared fabric clock
- Res_n  in  1  asynchronous active-low reset
- cpu_en  in  1  one-cycle strobe marking the single Clk cycle in which a CPU bus access is valid
- bus_addr  in  ADDR_W  CPU address
- bus_rw_n  in  1  1 = read, 0 = write
- bus_din  in  8  CPU write data
- bus_out  out  8  registered read data
- nmi_n  out  1  NMI to CPU, active low
- ctrl  out  8  PPUCTRL
- mask  out  8  PPUMASK
- t_addr  out  15  loopy t
- v_addr  out  15  loopy v
- fine_x  out  3  fine X scroll
- rend_v_we  in  1  renderer overwrites v
- rend_v  in  15  renderer's v value
- vblank_set  in  1  pulse: vblank start
- vblank_clr  in  1  pulse: pre-render line; clears all status flags
- spr0_set  in  1  pulse: sprite-0 hit
- ovf_set  in  1  pulse: sprite overflow
- vram_req  out  1  VRAM request, held until ack
- vram_we  out  1  1 = write
- vram_addr  out  VRAM_AW  equals v_addr[13:0] captured at request
- vram_wdata  out  8  write data
- vram_rdata  in  8  read data, valid with ack
- vram_ack  in  1  one-cycle completion
- err_ovr  out  1  sticky: $2007 access dropped while a request was pending

Behaviour:
- Reset values: all outputs 0 except nmi_n = 1. Internal w, rd_buf, io_latch and status flags all 0.
- Select: cs = cpu_en & (bus_addr[15:13] == 3'b001); reg = bus_addr[2:0]. Every side effect happens only on a cs cycle, exactly once per access.
- io_latch: loaded with bus_din on every cs write.
- Reads:
  - bus_out is updated on the cs-read edge and is valid from the next cycle (1-cycle latency, matching on-chip RAM). It holds its value until the next cs read.
  - Write-only registers return io_latch.
- $2000 write: ctrl <= d; t[11:10] <= d[1:0].
- $2001 write: mask <= d.
- $2002 read:
  - Returns {vbl, spr0, ovf, io_latch[4:0]}.
  - Then clears vbl and w.
  - If vblank_set coincides with this read: return bit7 = 0, vbl stays 0 for this frame.
- $2005 write:
  - w = 0: t[4:0] <= d[7:3]; fine_x <= d[2:0]; w <= 1.
  - w = 1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
- $2006 write:
  - w = 0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
  - w = 1: t[7:0] <= d; v <= new t; w <= 0.
  - If rend_v_we fires in the same cycle, the CPU write wins.
- $2007 common: increment = ctrl[2] ? 32 : 1. v wraps modulo 2^15.
- $2007 write: issue req (we = 1, addr = v, wdata = d); v += increment.
- $2007 read:
  - Return rd_buf immediately.
  - Issue req (we = 0, addr = v); v += increment.
  - On ack, rd_buf <= vram_rdata.
- VRAM port FSM:
  - States IDLE -> REQ (vram_req = 1) -> IDLE on vram_ack.
  - vram_addr, vram_we and vram_wdata are stable for the whole of REQ.
  - A $2007 access arriving in REQ is dropped: no v increment, no request; err_ovr <= 1 (cleared only by reset).
- Status flags:
  - vbl is set by vblank_set; spr0 and ovf are set by their pulses.
  - vblank_clr clears all three and wins over a simultaneous set.
- NMI: nmi_n <= ~(vbl & ctrl[7]), registered. Setting ctrl[7] while vbl = 1 drops nmi_n on the next cycle.
- rend_v_we: v <= rend_v when there is no CPU v update in the same cycle.
- Reset mid-request: FSM returns to IDLE and vram_req drops asynchronously. A late ack is ignored.

Optional Feature:
- Macro: PPU_OAM_PORT_EN.
- When defined, adds:
  - Ports: oam_addr out 8, oam_we out 1, oam_wdata out 8, oam_rdata in 8.
  - $2003 write: oam_addr <= d.
  - $2004 write: oam_we pulses for one cycle with oam_wdata = d; then oam_addr++ (wraps 255 -> 0).
  - $2004 read: returns oam_rdata, with no increment.
- When undefined: the ports are absent; $2003 and $2004 act as write-only/no-op and reads return io_latch.

Decomposition:
- Package ppu_pkg contains:
  - enum ppu_reg_e for the 8 register indices
  - localparams for loopy field slices (coarse X, coarse Y, nametable, fine Y)
  - the VRAM port state enum
- Natural sub-module ppu_loopy_regs: holds t/v/w/fine_x and implements the $2000/$2002/$2005/$2006 field logic plus rend_v arbitration.

Test Plan:
- Reset, then read $2000 and $2002 -> bus_out = 00, nmi_n = 1, vram_req = 0.
- Write $2006 = 0x21, then $2006 = 0x08 -> t = v = 0x2108, w = 0. A third write, $2006 = 0x3F, sets t[13:8] = 0x3F only.
- Write $2000 = 0x04, then $2007 = 0xAA twice with ack after 1 cycle -> VRAM writes 0xAA at 0x2108 and 0x2128, v = 0x2148.
- v = 0x2000; read $2007 twice with vram_rdata = 0x11 then 0x22 -> bus_out = 00 then 11; rd_buf = 22.
- vblank_set with ctrl = 0x80 -> nmi_n low next cycle. Reading $2002 returns 0x80 | io_latch[4:0]; then nmi_n goes high and a second read returns bit7 = 0. Separately, vblank_set on the same cycle as a $2002 read -> bit7 = 0, nmi_n stays 1.
- $2007 access while vram_ack is withheld -> second access dropped, v incremented once only, err_ovr = 1. Then assert Res_n low mid-REQ -> vram_req drops immediately.
